// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Upstream control stage for the 8:1 mux (A[7:0], S[2:0] -> Y). Accepts one
// byte per valid/ready handshake, holds it on A and steps S through 0..7, one
// step every DIV clocks. The mux decodes S=0 -> A[7] and S=7 -> A[0], so the
// byte appears on Y MSB-first.
//
// Parameters
//   DIV  clocks per bit period, 1..256
//   CW   divider counter width, 2**CW >= DIV
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     byte to serialise
//   in_valid    in_data is valid
//   in_ready    block can accept a byte this cycle
//   clr         synchronous abort back to IDLE (A is kept)
//   A           held byte, to mux A input
//   S           bit select, to mux S input
//   bit_strobe  pulse in the last cycle of each bit period
//   bit_first   S==0 while busy
//   bit_last    S==7 while busy
//   busy        state is SHIFT
//   done        pulse coinciding with the strobe of bit 7
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
   parameter int unsigned DIV = 4,
   parameter int unsigned CW  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       clr,
   output logic [7:0] A,
   output logic [2:0] S,
   output logic       bit_strobe,
   output logic       bit_first,
   output logic       bit_last,
   output logic       busy,
   output logic       done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   state_t        state;
   logic [7:0]    a_q;
   logic [2:0]    s_q;
   logic [CW-1:0] div_cnt;

   logic          period_end;
   logic          accept;

   // All handshake/strobe outputs are decoded from registered state; clr
   // only masks them so an abort cycle never looks like a completed bit.
   always_comb begin
      period_end = (state == SHIFT) && (div_cnt == DIV_LAST);
      bit_strobe = period_end && !clr;
      done       = bit_strobe && (s_q == 3'd7);
      // Ready in IDLE, or on the final strobe so the next byte follows
      // without a gap cycle.
      in_ready   = (state == IDLE) || done;
      accept     = in_valid && in_ready && !clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         s_q     <= '0;
         div_cnt <= '0;
      end else if (clr) begin
         state   <= IDLE;
         s_q     <= '0;
         div_cnt <= '0;
      end else if (accept) begin
         state   <= SHIFT;
         a_q     <= in_data;
         s_q     <= '0;
         div_cnt <= '0;
      end else if (state == SHIFT) begin
         if (period_end) begin
            div_cnt <= '0;
            // 3-bit wrap returns S to 0 after bit 7.
            s_q     <= s_q + 3'd1;
            if (s_q == 3'd7) begin
               state <= IDLE;
            end
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      A         = a_q;
      S         = s_q;
      busy      = (state == SHIFT);
      bit_first = (state == SHIFT) && (s_q == 3'd0);
      bit_last  = (state == SHIFT) && (s_q == 3'd7);
   end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_sequencer
//
// Directed bench for mux_sel_sequencer. Two instances share clk/rst_n: one
// with DIV=4 and one with DIV=1. Y is reconstructed with a local model of the
// 8:1 mux (S=0 -> A[7]) and compared against hand-computed bit patterns.
// -----------------------------------------------------------------------------
module tb_mux_sel_sequencer;

   logic clk;
   logic rst_n;

   // DIV=4 instance
   logic [7:0] in_data4;
   logic       in_valid4;
   logic       in_ready4;
   logic       clr4;
   logic [7:0] a4;
   logic [2:0] s4;
   logic       strobe4, first4, last4, busy4, done4;

   // DIV=1 instance
   logic [7:0] in_data1;
   logic       in_valid1;
   logic       in_ready1;
   logic       clr1;
   logic [7:0] a1;
   logic [2:0] s1;
   logic       strobe1, first1, last1, busy1, done1;

   int tests;
   int fails;

   mux_sel_sequencer #(.DIV(4), .CW(8)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data4),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .clr        (clr4),
      .A          (a4),
      .S          (s4),
      .bit_strobe (strobe4),
      .bit_first  (first4),
      .bit_last   (last4),
      .busy       (busy4),
      .done       (done4)
   );

   mux_sel_sequencer #(.DIV(1), .CW(8)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data1),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .clr        (clr1),
      .A          (a1),
      .S          (s1),
      .bit_strobe (strobe1),
      .bit_first  (first1),
      .bit_last   (last1),
      .busy       (busy1),
      .done       (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ymux(input logic [7:0] a, input logic [2:0] s);
      return a[3'd7 - s];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_y;
   logic [7:0] got_byte;
   int         nstr;
   int         ndone;

   initial begin
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      in_data4  = '0;
      in_valid4 = 1'b0;
      clr4      = 1'b0;
      in_data1  = '0;
      in_valid1 = 1'b0;
      clr1      = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("rst_a",      a4,        8'h00);
      check("rst_s",      s4,        3'd0);
      check("rst_busy",   busy4,     1'b0);
      check("rst_strobe", strobe4,   1'b0);
      check("rst_done",   done4,     1'b0);
      check("rst_ready",  in_ready4, 1'b1);
      check("rst_busy1",  busy1,     1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- single byte A5, DIV=4 ----------------
      exp_y     = 8'b1010_0101;
      in_data4  = 8'hA5;
      in_valid4 = 1'b1;
      #1;
      check("t1_ready_idle", in_ready4, 1'b1);
      tick();                      // accept edge t0
      in_valid4 = 1'b0;
      in_data4  = 8'h00;
      #1;
      for (int c = 0; c < 32; c++) begin
         check("t1_s",      s4,        c / 4);
         check("t1_strobe", strobe4,   (c % 4) == 3);
         check("t1_done",   done4,     c == 31);
         check("t1_first",  first4,    c < 4);
         check("t1_last",   last4,     c >= 28);
         check("t1_busy",   busy4,     1'b1);
         check("t1_ready",  in_ready4, c == 31);
         check("t1_a",      a4,        8'hA5);
         if ((c % 4) == 3)
            check("t1_y", ymux(a4, s4), exp_y[7 - c / 4]);
         tick();
      end
      check("t1_end_busy",  busy4,     1'b0);
      check("t1_end_ready", in_ready4, 1'b1);
      check("t1_end_s",     s4,        3'd0);
      check("t1_end_a",     a4,        8'hA5);

      // ---------------- back-to-back FF then 00, DIV=1 ----------------
      in_data1  = 8'hFF;
      in_valid1 = 1'b1;
      tick();                      // first accept
      in_data1 = 8'h00;
      #1;
      for (int c = 0; c < 16; c++) begin
         check("t2_strobe", strobe1,   1'b1);
         check("t2_s",      s1,        c % 8);
         check("t2_done",   done1,     (c == 7) || (c == 15));
         check("t2_busy",   busy1,     1'b1);
         check("t2_y",      ymux(a1, s1), c < 8);
         check("t2_a",      a1,        (c < 8) ? 8'hFF : 8'h00);
         tick();
         if (c == 8) in_valid1 = 1'b0;
      end
      check("t2_end_busy", busy1, 1'b0);

      // ---------------- backpressure C3 then 3C, DIV=4 ----------------
      in_data4  = 8'hC3;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      #1;
      for (int c = 0; c < 32; c++) begin
         if (c == 5) begin
            in_data4  = 8'h3C;
            in_valid4 = 1'b1;
            #1;
         end
         check("t3_ready", in_ready4, c == 31);
         check("t3_a",     a4,        8'hC3);
         check("t3_s",     s4,        c / 4);
         tick();
      end
      in_valid4 = 1'b0;
      #1;
      check("t3_reload_a",    a4,    8'h3C);
      check("t3_reload_s",    s4,    3'd0);
      check("t3_reload_busy", busy4, 1'b1);

      // ---------------- clr mid-byte at S=3 ----------------
      for (int c = 0; c < 15; c++) tick();
      check("t4_pre_s",      s4,      3'd3);
      check("t4_pre_strobe", strobe4, 1'b1);
      clr4 = 1'b1;
      #1;
      check("t4_clr_strobe", strobe4,   1'b0);
      check("t4_clr_done",   done4,     1'b0);
      check("t4_clr_ready",  in_ready4, 1'b0);
      tick();
      clr4 = 1'b0;
      #1;
      check("t4_busy",   busy4,     1'b0);
      check("t4_s",      s4,        3'd0);
      check("t4_strobe", strobe4,   1'b0);
      check("t4_ready",  in_ready4, 1'b1);
      check("t4_a",      a4,        8'h3C);
      nstr  = 0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         if (strobe4) nstr++;
         if (done4)   ndone++;
         tick();
      end
      check("t4_no_strobe", nstr,  0);
      check("t4_no_done",   ndone, 0);

      // ---------------- async reset mid-byte at S=5 ----------------
      in_data4  = 8'h55;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      for (int c = 0; c < 21; c++) tick();
      check("t5_pre_s", s4, 3'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy",   busy4,     1'b0);
      check("t5_rst_s",      s4,        3'd0);
      check("t5_rst_a",      a4,        8'h00);
      check("t5_rst_strobe", strobe4,   1'b0);
      check("t5_rst_done",   done4,     1'b0);
      check("t5_rst_ready",  in_ready4, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      in_data4  = 8'h81;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      #1;
      got_byte = '0;
      nstr     = 0;
      ndone    = 0;
      for (int c = 0; c < 32; c++) begin
         if (strobe4) begin
            got_byte = {got_byte[6:0], ymux(a4, s4)};
            nstr++;
         end
         if (done4) begin
            ndone++;
            check("t5_done_pos", c, 31);
         end
         tick();
      end
      check("t5_byte",  got_byte, 8'h81);
      check("t5_nstr",  nstr,     8);
      check("t5_ndone", ndone,    1);
      check("t5_busy",  busy4,    1'b0);

      // ---------------- clr with in_valid while IDLE ----------------
      clr4      = 1'b1;
      in_data4  = 8'h5A;
      in_valid4 = 1'b1;
      #1;
      check("t6_ready", in_ready4, 1'b1);
      tick();
      clr4      = 1'b0;
      in_valid4 = 1'b0;
      #1;
      check("t6_a",    a4,    8'h81);
      check("t6_s",    s4,    3'd0);
      check("t6_busy", busy4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream control stage for the team's 8:1 gate-level mux (data A[7:0], select S[2:0], output Y).
- Accepts one byte per handshake, holds it stable on A, and steps S through 0..7 at a programmable bit period. The mux then emits the byte on Y serially.
- Mux decode is fixed: S=0 selects A[7] and S=7 selects A[0]. The sequence is therefore MSB-first.
- Provides per-bit strobe, first/last flags and an end-of-byte pulse for the downstream consumer of Y.

Parameters:
- DIV, 4, clocks per bit period; legal range 1..256.
- CW, 8, width of the internal divider counter; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  byte to serialise
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a byte this cycle
- clr  input  1  synchronous abort; returns the block to IDLE
- A  output  8  held byte, wired to the mux A input
- S  output  3  bit select, wired to the mux S input
- bit_strobe  output  1  one-clock pulse in the last cycle of each bit period
- bit_first  output  1  high whenever S==0 and busy=1
- bit_last  output  1  high whenever S==7 and busy=1
- busy  output  1  state is SHIFT
- done  output  1  one-clock pulse coinciding with the strobe of bit 7

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, A=8'h00, S=3'd0, div_cnt=0, bit_strobe=0, done=0, busy=0. in_ready reads 1 once the state is IDLE. Upstream must not assert in_valid while rst_n=0.
- States: IDLE and SHIFT.
- in_ready = (state==IDLE) | (state==SHIFT & S==7 & div_cnt==DIV-1 & !clr). It is combinational from registered state.
- Accept occurs on any clock where in_valid & in_ready. At that edge: A<=in_data, S<=0, div_cnt<=0, state<=SHIFT.
- SHIFT timing:
  - div_cnt increments every clock.
  - When div_cnt==DIV-1: bit_strobe=1, div_cnt<=0, S<=S+1.
  - When S==7 on that strobe, done=1 as well.
  - S wraps 7->0 with 3-bit arithmetic.
- bit_strobe and done are combinational from registered state, valid in the same cycle as the condition above.
- End of byte:
  - If no accept occurs on the bit-7 strobe: state<=IDLE, S<=0, A holds its value.
  - If an accept occurs on the same cycle: reload in_data, S<=0, stay in SHIFT. The next byte starts with no gap cycle.
- Period and latency:
  - Each bit is presented on S for exactly DIV clocks.
  - One byte takes 8*DIV clocks from the accept edge to the edge after done.
  - Y is valid for bit k from the edge that sets S=k; sample Y on bit_strobe.
- DIV=1: bit_strobe is high every SHIFT cycle, S advances every clock, and a byte takes 8 clocks.
- Stability: A changes only on an accept edge. in_valid/in_data are ignored while in_ready=0, and A never changes mid-byte.
- clr:
  - clr=1 at any edge forces state<=IDLE, S<=0, div_cnt<=0, and the block does not accept in that cycle.
  - While clr=1, bit_strobe and done are 0.
  - A is not cleared.
  - clr has priority over accept and over strobe.
- Async reset mid-byte: all state returns to reset values immediately with no partial done. The first post-reset accept starts a full fresh byte.
- Divider counter is CW bits wide; a DIV outside 1..256 is a configuration error.

Test Plan:
- Single byte, DIV=4: in_data=8'hA5 accepted at edge t0.
  - S steps 0..7 every 4 clocks.
  - Mux Y sampled on strobes = 1,0,1,0,0,1,0,1.
  - bit_first on S=0, bit_last on S=7, done at clock t0+31, busy low at t0+32, in_ready=1.
- Back-to-back, DIV=1: in_valid held high with 8'hFF then 8'h00.
  - Second accept occurs on the bit-7 strobe cycle.
  - Exactly 16 consecutive strobes with Y=1x8 then 0x8 and no idle gap.
  - done pulses at clocks 7 and 15.
- Backpressure: present in_valid with 8'h3C mid-byte of 8'hC3.
  - in_ready=0 until the bit-7 strobe; A stays 8'hC3 through all 8 bits.
  - 8'h3C loads on the bit-7 strobe cycle.
- clr mid-byte, DIV=4: pulse clr during S=3.
  - Next cycle: state IDLE, S=0, busy=0, no strobe.
  - Never done; in_ready=1.
- Async reset mid-byte: drop rst_n during S=5.
  - Outputs go to reset values immediately.
  - After release, accepting 8'h81 yields 8 full bits, Y=1,0,0,0,0,0,0,1, and a single done.
- Simultaneous clr and accept: clr=1 in an IDLE cycle with in_valid=1.
  - No accept; A unchanged; S=0; busy stays 0.
